// File: rtl/tlx_axi_mem_responder.sv
// AXI4 slave memory model answering reverse-direction TLX traffic; FIXED/INCR/WRAP, strobes, SLVERR.
// Optional macro TLX_MEM_RANDOM_STALL_EN adds LFSR-driven stalls on AWREADY/WREADY/ARREADY and R_WAIT.
module tlx_axi_mem_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MEM_AW       = 10,
    parameter int          READ_LATENCY = 2
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [3:0]  AWID,
    input  logic [31:0] AWADDR,
    input  logic [7:0]  AWLEN,
    input  logic [2:0]  AWSIZE,
    input  logic [1:0]  AWBURST,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [63:0] WDATA,
    input  logic [7:0]  WSTRB,
    input  logic        WLAST,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [3:0]  BID,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [3:0]  ARID,
    input  logic [31:0] ARADDR,
    input  logic [7:0]  ARLEN,
    input  logic [2:0]  ARSIZE,
    input  logic [1:0]  ARBURST,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [3:0]  RID,
    output logic [63:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RLAST,
    output logic        RVALID,
    input  logic        RREADY
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    localparam logic [32:0] WIN_BYTES = 33'd8 << MEM_AW;
    localparam logic [3:0]  LAT       = 4'(READ_LATENCY);

    function automatic logic wrap_bad(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b10) &&
               !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    endfunction

    // A below-window address wraps the 33-bit difference high, so one compare covers both ends.
    function automatic logic beat_err(input logic [31:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
        logic [32:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        return (diff >= WIN_BYTES) || (size > 3'd3) || wrap_bad(burst, len);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] mask;
        logic [31:0] result;
        step   = 32'd1 << size;
        mask   = (({24'd0, len} + 32'd1) << size) - 32'd1;
        result = addr + step;
        if (burst == 2'b00)
            result = addr;
        else if ((burst == 2'b10) && !wrap_bad(burst, len))
            result = (addr & ~mask) | ((addr + step) & mask);
        return result;
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] addr);
        return MEM_AW'((addr - BASE_ADDR) >> 3);
    endfunction

    logic [63:0] mem [2**MEM_AW];

    w_state_t    w_state;
    logic        aw_rdy, w_rdy;
    logic [3:0]  wr_id;
    logic [31:0] wr_addr;
    logic [7:0]  wr_len, wr_cnt;
    logic [2:0]  wr_size;
    logic [1:0]  wr_burst;
    logic        wr_err;
    logic        aw_hs, w_hs, wr_beat_err, w_beat_flag, mem_we;

    r_state_t    r_state;
    logic        ar_rdy;
    logic [3:0]  rd_id, wait_cnt;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len, rd_cnt;
    logic [2:0]  rd_size;
    logic [1:0]  rd_burst;
    logic        ar_hs, wait_hold, wait_done, do_load;
    logic [31:0] ld_addr;
    logic [7:0]  ld_len, ld_cnt;
    logic [2:0]  ld_size;
    logic [1:0]  ld_burst;
    logic [3:0]  ld_id;
    logic        ld_err;
    logic [63:0] ld_data;

`ifdef TLX_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr;
    logic        extra_used;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // The extra R_WAIT cycle is granted at most once per terminal count.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            extra_used <= 1'b0;
        else if (r_state != R_WAIT)
            extra_used <= 1'b0;
        else if (wait_hold)
            extra_used <= 1'b1;
    end

    assign AWREADY   = aw_rdy & ~lfsr[0];
    assign WREADY    = w_rdy & ~lfsr[5];
    assign ARREADY   = ar_rdy & ~lfsr[10];
    assign wait_hold = (wait_cnt == 4'd1) && lfsr[15] && !extra_used;
`else
    assign AWREADY   = aw_rdy;
    assign WREADY    = w_rdy;
    assign ARREADY   = ar_rdy;
    assign wait_hold = 1'b0;
`endif

    assign aw_hs       = AWVALID && AWREADY;
    assign w_hs        = WVALID && WREADY;
    assign wr_beat_err = beat_err(wr_addr, wr_len, wr_size, wr_burst);
    assign w_beat_flag = wr_beat_err || (WLAST != (wr_cnt == 8'd0));
    assign mem_we      = (w_state == W_DATA) && w_hs && !wr_beat_err;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state  <= W_IDLE;
            aw_rdy   <= 1'b1;
            w_rdy    <= 1'b0;
            BVALID   <= 1'b0;
            BID      <= 4'd0;
            BRESP    <= 2'b00;
            wr_id    <= 4'd0;
            wr_addr  <= 32'd0;
            wr_len   <= 8'd0;
            wr_cnt   <= 8'd0;
            wr_size  <= 3'd0;
            wr_burst <= 2'b00;
            wr_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    wr_id    <= AWID;
                    wr_addr  <= AWADDR;
                    wr_len   <= AWLEN;
                    wr_cnt   <= AWLEN;
                    wr_size  <= AWSIZE;
                    wr_burst <= AWBURST;
                    wr_err   <= 1'b0;
                    aw_rdy   <= 1'b0;
                    w_rdy    <= 1'b1;
                    w_state  <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    wr_addr <= next_addr(wr_addr, wr_len, wr_size, wr_burst);
                    wr_cnt  <= wr_cnt - 8'd1;
                    wr_err  <= wr_err | w_beat_flag;
                    if (wr_cnt == 8'd0) begin
                        w_rdy   <= 1'b0;
                        BVALID  <= 1'b1;
                        BID     <= wr_id;
                        BRESP   <= (wr_err || w_beat_flag) ? 2'b10 : 2'b00;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (BREADY) begin
                    BVALID  <= 1'b0;
                    aw_rdy  <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Array contents survive reset.
    always_ff @(posedge ACLK) begin
        if (mem_we)
            for (int b = 0; b < 8; b++)
                if (WSTRB[b])
                    mem[word_idx(wr_addr)][8*b +: 8] <= WDATA[8*b +: 8];
    end

    // In R_IDLE a zero-latency load takes its burst fields straight from the AR channel.
    assign ar_hs     = ARVALID && ARREADY;
    assign ld_addr   = (r_state == R_IDLE) ? ARADDR  : rd_addr;
    assign ld_len    = (r_state == R_IDLE) ? ARLEN   : rd_len;
    assign ld_cnt    = (r_state == R_IDLE) ? ARLEN   : rd_cnt;
    assign ld_size   = (r_state == R_IDLE) ? ARSIZE  : rd_size;
    assign ld_burst  = (r_state == R_IDLE) ? ARBURST : rd_burst;
    assign ld_id     = (r_state == R_IDLE) ? ARID    : rd_id;
    assign ld_err    = beat_err(ld_addr, ld_len, ld_size, ld_burst);
    assign ld_data   = ld_err ? 64'd0 : mem[word_idx(ld_addr)];
    assign wait_done = (wait_cnt == 4'd1) && !wait_hold;
    assign do_load   = ((r_state == R_IDLE) && ar_hs && (LAT == 4'd0)) ||
                       ((r_state == R_WAIT) && wait_done) ||
                       ((r_state == R_DATA) && RREADY && !RLAST);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state  <= R_IDLE;
            ar_rdy   <= 1'b1;
            RVALID   <= 1'b0;
            RLAST    <= 1'b0;
            RID      <= 4'd0;
            RDATA    <= 64'd0;
            RRESP    <= 2'b00;
            rd_id    <= 4'd0;
            rd_addr  <= 32'd0;
            rd_len   <= 8'd0;
            rd_cnt   <= 8'd0;
            rd_size  <= 3'd0;
            rd_burst <= 2'b00;
            wait_cnt <= 4'd0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    rd_id    <= ARID;
                    rd_addr  <= ARADDR;
                    rd_len   <= ARLEN;
                    rd_cnt   <= ARLEN;
                    rd_size  <= ARSIZE;
                    rd_burst <= ARBURST;
                    wait_cnt <= LAT;
                    ar_rdy   <= 1'b0;
                    r_state  <= R_WAIT;
                end
                R_WAIT: if (wait_cnt != 4'd1)
                    wait_cnt <= wait_cnt - 4'd1;
                R_DATA: if (RREADY && RLAST) begin
                    RVALID  <= 1'b0;
                    RLAST   <= 1'b0;
                    ar_rdy  <= 1'b1;
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
            if (do_load) begin
                RID     <= ld_id;
                RDATA   <= ld_data;
                RRESP   <= ld_err ? 2'b10 : 2'b00;
                RLAST   <= (ld_cnt == 8'd0);
                RVALID  <= 1'b1;
                rd_addr <= next_addr(ld_addr, ld_len, ld_size, ld_burst);
                rd_cnt  <= ld_cnt - 8'd1;
                r_state <= R_DATA;
            end
        end
    end

endmodule

// File: tb/tb_tlx_axi_mem_responder.sv
// Directed self-checking bench for tlx_axi_mem_responder (default build, READ_LATENCY=2, 8 KB window).
module tb_tlx_axi_mem_responder;

    localparam int LAT = 2;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [63:0] WDATA = '0;
    logic [7:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [3:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [63:0] wdata_q  [16];
    logic [63:0] exp_data [16];
    logic [1:0]  exp_resp [16];

    tlx_axi_mem_responder #(.BASE_ADDR(32'h0), .MEM_AW(10), .READ_LATENCY(LAT)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [7:0] strb,
                               input logic [1:0] resp, input int bhold);
        int n;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd3; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 100) begin step(); n++; end
        check_output("awready", AWREADY, 1);
        step();
        AWVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            WDATA = wdata_q[b]; WSTRB = strb; WLAST = (b == int'(len)); WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 100) begin step(); n++; end
            check_output("wready", WREADY, 1);
            step();
        end
        WVALID = 1'b0; WLAST = 1'b0;
        n = 0;
        while (!BVALID && n < 100) begin step(); n++; end
        check_output("bvalid", BVALID, 1);
        check_output("bid", BID, id);
        check_output("bresp", BRESP, resp);
        for (int h = 0; h < bhold; h++) begin
            step();
            check_output("bvalid_hold", BVALID, 1);
            check_output("bid_hold", BID, id);
            check_output("bresp_hold", BRESP, resp);
        end
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        check_output("bvalid_drop", BVALID, 0);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input int stall_beat, input int stall_cycles);
        int n;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd3; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 100) begin step(); n++; end
        check_output("arready", ARREADY, 1);
        step();
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 100) begin step(); n++; end
        check_output("r_latency", n + 1, LAT + 1);
        for (int b = 0; b <= int'(len); b++) begin
            check_output("rvalid", RVALID, 1);
            check_output("rid", RID, id);
            check_output("rdata", RDATA, exp_data[b]);
            check_output("rresp", RRESP, exp_resp[b]);
            check_output("rlast", RLAST, (b == int'(len)));
            if (b == stall_beat)
                for (int h = 0; h < stall_cycles; h++) begin
                    step();
                    check_output("rvalid_hold", RVALID, 1);
                    check_output("rdata_hold", RDATA, exp_data[b]);
                    check_output("rlast_hold", RLAST, (b == int'(len)));
                end
            RREADY = 1'b1;
            step();
            RREADY = 1'b0;
        end
        check_output("rvalid_end", RVALID, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) step();
        check_output("rst_awready", AWREADY, 1);
        check_output("rst_arready", ARREADY, 1);
        check_output("rst_wready", WREADY, 0);
        check_output("rst_bvalid", BVALID, 0);
        check_output("rst_rvalid", RVALID, 0);
        check_output("rst_rlast", RLAST, 0);
        check_output("rst_ids", {BID, RID}, 0);
        check_output("rst_resps", {BRESP, RRESP}, 0);
        check_output("rst_rdata", RDATA, 0);
        ARESETn = 1'b1;
        step();

        // INCR write of words 0x10..0x28, then read back.
        wdata_q[0] = 64'h1111_1111_1111_1111; wdata_q[1] = 64'h2222_2222_2222_2222;
        wdata_q[2] = 64'h3333_3333_3333_3333; wdata_q[3] = 64'h4444_4444_4444_4444;
        write_burst(4'h5, 32'h10, 8'd3, 2'b01, 8'hFF, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin exp_data[i] = wdata_q[i]; exp_resp[i] = 2'b00; end
        read_burst(4'h6, 32'h10, 8'd3, 2'b01, -1, 0);

        // Back-pressure on B while filling 0x30/0x38, then on R mid-burst.
        wdata_q[0] = 64'h5555_5555_5555_5555; wdata_q[1] = 64'h6666_6666_6666_6666;
        write_burst(4'h9, 32'h30, 8'd1, 2'b01, 8'hFF, 2'b00, 5);
        read_burst(4'h3, 32'h10, 8'd3, 2'b01, 1, 3);

        // WRAP from 0x38 in a 32-byte block: 0x38, 0x20, 0x28, 0x30.
        exp_data[0] = 64'h6666_6666_6666_6666; exp_data[1] = 64'h3333_3333_3333_3333;
        exp_data[2] = 64'h4444_4444_4444_4444; exp_data[3] = 64'h5555_5555_5555_5555;
        for (int i = 0; i < 4; i++) exp_resp[i] = 2'b00;
        read_burst(4'hA, 32'h38, 8'd3, 2'b10, -1, 0);

        // Byte strobes merge the low half only.
        wdata_q[0] = 64'h1234_5678_9ABC_DEF0;
        write_burst(4'h1, 32'h100, 8'd0, 2'b01, 8'hFF, 2'b00, 0);
        wdata_q[0] = 64'hAAAA_AAAA_BBBB_BBBB;
        write_burst(4'h2, 32'h100, 8'd0, 2'b01, 8'h0F, 2'b00, 0);
        exp_data[0] = 64'h1234_5678_BBBB_BBBB; exp_resp[0] = 2'b00;
        read_burst(4'h2, 32'h100, 8'd0, 2'b01, -1, 0);

        // Second beat crosses the window end at 0x2000.
        wdata_q[0] = 64'h7777_7777_7777_7777; wdata_q[1] = 64'h8888_8888_8888_8888;
        write_burst(4'hC, 32'h1FF8, 8'd1, 2'b01, 8'hFF, 2'b10, 0);
        exp_data[0] = 64'h7777_7777_7777_7777; exp_resp[0] = 2'b00;
        exp_data[1] = 64'h0;                   exp_resp[1] = 2'b10;
        read_burst(4'hD, 32'h1FF8, 8'd1, 2'b01, -1, 0);

        // Reset while beat 2 of 4 is presented.
        ARID = 4'h7; ARADDR = 32'h10; ARLEN = 8'd3; ARSIZE = 3'd3; ARBURST = 2'b01; ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        for (int n = 0; n < 100 && !RVALID; n++) step();
        check_output("mid_beat1", RDATA, 64'h1111_1111_1111_1111);
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        check_output("mid_beat2", RDATA, 64'h2222_2222_2222_2222);
        ARESETn = 1'b0;
        #1;
        check_output("mid_rst_rvalid", RVALID, 0);
        step();
        step();
        ARESETn = 1'b1;
        check_output("post_rst_arready", ARREADY, 1);
        step();
        exp_data[0] = 64'h1234_5678_BBBB_BBBB; exp_resp[0] = 2'b00;
        read_burst(4'hE, 32'h100, 8'd0, 2'b01, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
